// File: rtl/mladd_pkg.sv
// mladd_pkg: shared types and constants for the wide-add sequencer
package mladd_pkg;
  localparam int SLICE_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mlcladder.sv
// mlcladder: 16-bit two-level carry-lookahead adder
// Ports: a, b (16-bit addends), cin (carry in), sum (16-bit result), cout (carry out).
module mlcladder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g, p, c;
  logic [3:0] gg, pg, t;
  logic [4:0] gc;
  // 4-bit lookahead unit, reused at bit level inside a group and at group level
  function automatic logic [3:0] cla4(input logic [3:0] gi, input logic [3:0] pi, input logic ci);
    cla4[0] = gi[0] | (pi[0] & ci);
    cla4[1] = gi[1] | (pi[1] & gi[0]) | (&pi[1:0] & ci);
    cla4[2] = gi[2] | (pi[2] & gi[1]) | (&pi[2:1] & gi[0]) | (&pi[2:0] & ci);
    cla4[3] = gi[3] | (pi[3] & gi[2]) | (&pi[3:2] & gi[1]) | (&pi[3:1] & gi[0]) | (&pi & ci);
  endfunction
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    gg = '0;
    pg = '0;
    c = '0;
    t = '0;
    for (int j = 0; j < 4; j++) begin
      t = cla4(g[4*j +: 4], p[4*j +: 4], 1'b0);
      gg[j] = t[3];
      pg[j] = &p[4*j +: 4];
    end
    gc = {cla4(gg, pg, cin), cin};
    for (int j = 0; j < 4; j++) begin
      t = cla4(g[4*j +: 4], p[4*j +: 4], gc[j]);
      c[4*j +: 4] = {t[2:0], gc[j]};
    end
  end
  assign sum = p ^ c;
  assign cout = gc[4];
endmodule

// File: rtl/mladd_seq.sv
// mladd_seq: wide add sequencer driving one 16-bit mlcladder slice per cycle, LSW first
// Ports: clk, rst_n (async active-low); in_valid/in_ready + a, b, cin (+ op_sub) request;
//        out_valid/out_ready + sum, cout result; busy = not idle.
// Optional: define MLADD_SEQ_ADD_SUB_EN to add op_sub (A - B as A + ~B + 1).
module mladd_seq
  import mladd_pkg::*;
#(
  parameter int DW    = SLICE_W,
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW*WORDS-1:0] a,
  input  logic [DW*WORDS-1:0] b,
  input  logic                cin,
`ifdef MLADD_SEQ_ADD_SUB_EN
  input  logic                op_sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW*WORDS-1:0] sum,
  output logic                cout,
  output logic                busy
);
  localparam int W  = DW * WORDS;
  localparam int IW = idx_w(WORDS);
  state_t state;
  logic [IW-1:0] idx;
  logic cy, sub_r, s_cout;
  logic [W-1:0] a_r, b_r;
  logic [DW-1:0] s_a, s_b, s_sum;
`ifndef MLADD_SEQ_ADD_SUB_EN
  assign sub_r = 1'b0;
`endif
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign s_a = a_r[idx*DW +: DW];
  assign s_b = b_r[idx*DW +: DW] ^ {DW{sub_r}};
  mlcladder u_add (.a(s_a), .b(s_b), .cin(cy), .sum(s_sum), .cout(s_cout));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      cy <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      sum <= '0;
      cout <= 1'b0;
      out_valid <= 1'b0;
`ifdef MLADD_SEQ_ADD_SUB_EN
      sub_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= b;
          idx <= '0;
          state <= RUN;
`ifdef MLADD_SEQ_ADD_SUB_EN
          sub_r <= op_sub;
          cy <= op_sub | cin;
`else
          cy <= cin;
`endif
        end
        RUN: begin
          sum[idx*DW +: DW] <= s_sum;
          cy <= s_cout;
          idx <= idx + 1'b1;
          if (idx == IW'(WORDS - 1)) begin
            cout <= s_cout;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mladd_seq.sv
// tb_mladd_seq: scoreboard bench for mladd_seq with directed vectors
module tb_mladd_seq;
  localparam int DW = 16;
  localparam int WORDS = 4;
  localparam int W = DW * WORDS;
  typedef struct {
    logic [W:0] r;
    int acc;
  } exp_t;
  logic clk = 0, rst_n = 0, in_valid = 0, cin = 0, op_sub = 0, out_ready = 1;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, busy;
  logic [W-1:0] sum;
  int errors = 0, checks = 0, cyc = 0;
  logic ov_prev = 0;
  exp_t sb[$];
  mladd_seq #(.DW(DW), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef MLADD_SEQ_ADD_SUB_EN
    .op_sub(op_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // monitor: latency on out_valid rise, result compare on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("latency", (W+1)'(cyc - sb[0].acc), (W+1)'(WORDS));
      end
      if (out_valid && out_ready && sb.size() != 0) chk("result", {cout, sum}, sb.pop_front().r);
    end
    ov_prev <= out_valid;
  end
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    a = ta; b = tb; cin = tc; op_sub = ts; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    a = 'x; b = 'x; cin = 1'bx;
    e.acc = cyc;
`ifdef MLADD_SEQ_ADD_SUB_EN
    e.r = ts ? {1'b0, ta} + {1'b0, ~tb} + 1 : {1'b0, ta} + {1'b0, tb} + tc;
`else
    e.r = {1'b0, ta} + {1'b0, tb} + tc;
`endif
    sb.push_back(e);
  endtask
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  initial begin
    logic [W:0] held;
    rst_n = 0;
    tick(3);
    chk("in_ready_in_reset", in_ready, 1);
    rst_n = 1;
    tick(1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    send(64'h0000_0000_0000_FFFF, 64'h1, 0, 0);
    sb[$].r = {1'b0, 64'h0000_0000_0001_0000};
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0);
    sb[$].r = {1'b1, 64'h0};
    send(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 0, 0);
    sb[$].r = {1'b1, 64'h0000_0001_0000_0000};
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0);
    sb[$].r = {1'b1, 64'h0};
    tick(8);
    out_ready = 0;
    send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 0, 0);
    sb[$].r = {1'b0, 64'h2345_6789_ABCD_F001};
    held = sb[$].r;
    tick(WORDS);
    a = 64'h55; b = 64'h66; cin = 0; in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result", {cout, sum}, held);
      chk("bp_in_ready", in_ready, 0);
      tick(1);
    end
    in_valid = 0;
    out_ready = 1;
    tick(1);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    tick(2);
    chk("bp_no_accept_busy", busy, 0);
    send(64'h5, 64'h6, 0, 0);
    tick(2);
    rst_n = 0;
    sb.delete();
    tick(2);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      chk("midrst_never_valid", out_valid, 0);
      tick(1);
    end
    send(64'h3, 64'h4, 1, 0);
    sb[$].r = {1'b0, 64'h8};
`ifdef MLADD_SEQ_ADD_SUB_EN
    send(64'h5, 64'h7, 0, 1);
    sb[$].r = {1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
    send(64'h7, 64'h5, 0, 1);
    sb[$].r = {1'b1, 64'h2};
    for (int i = 0; i < 1000; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
`else
    for (int i = 0; i < 200; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 0);
`endif
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) chk("drain_timeout", (W+1)'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
